rr_arbiter16: RTL and testbench



---
 rtl/rr_arbiter16.sv | 128 ++++++++++++
 tb/tb_rr_arbiter16.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with a registered grant index and one-hot decode.
// Optional hold-time limit with forced release is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter16 #(
  parameter int unsigned HOLD_MAX = 32,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_arbiter16: illegal HOLD_MAX/CNT_W combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  grant_idx_n;
  logic        grant_valid_n;
  logic        win_found;
  logic [3:0]  win_idx;
  logic        release_req;

  // Circular priority search starting at ptr; index arithmetic wraps at 4 bits.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!win_found && req[ptr + 4'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 4'(i);
      end
    end
  end

  assign release_req = done | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n, hold_inc;
  logic             timeout_n;

  assign hold_inc = (hold_cnt == CNT_W'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
`endif

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n    = hold_cnt;
    timeout_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_idx_n   = win_idx;
          grant_valid_n = 1'b1;
          state_n       = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n    = '0;
`endif
        end
      end
      BUSY: begin
        if (release_req) begin
          grant_valid_n = 1'b0;
          ptr_n         = grant_idx + 4'd1;
          state_n       = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // Forced release on the HOLD_MAX-th busy cycle; a normal release wins.
        else if (hold_inc == CNT_W'(HOLD_MAX)) begin
          grant_valid_n = 1'b0;
          ptr_n         = grant_idx + 4'd1;
          state_n       = IDLE;
          timeout_n     = 1'b1;
          hold_cnt_n    = hold_inc;
        end else begin
          hold_cnt_n    = hold_inc;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_valid <= grant_valid_n;
      grant_idx   <= grant_idx_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      timeout  <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: reset, single grant, round-robin order,
// wrap priority, request drop and hold-time behaviour (both builds).
module tb_rr_arbiter16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  int unsigned checks;
  int unsigned errors;

  rr_arbiter16 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Checks valid, index and one-hot decode together.
  task automatic check_grant(input string tag, input logic v, input logic [3:0] idx);
    logic [15:0] oh;
    oh = '0;
    if (v) oh[idx] = 1'b1;
    check({tag, "_valid"}, {31'd0, grant_valid}, {31'd0, v});
    check({tag, "_idx"}, {28'd0, grant_idx}, {28'd0, idx});
    check({tag, "_onehot"}, {16'd0, grant_onehot}, {16'd0, oh});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    check_grant("rst", 1'b0, 4'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    tick();
    check_grant("idle_noreq", 1'b0, 4'd0);

    // Single requester 3, ptr=0
    req = 16'h0008;
    tick();
    check_grant("single_grant", 1'b1, 4'd3);
    tick(); tick(); tick();
    check_grant("single_hold", 1'b1, 4'd3);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_grant("single_release", 1'b0, 4'd3);
    tick();
    check_grant("single_regrant", 1'b1, 4'd3);
    req = '0;
    tick();
    check_grant("single_drop", 1'b0, 4'd3);
    // ptr=4; done in IDLE must be ignored
    done = 1'b1;
    tick();
    done = 1'b0;
    check_grant("idle_done", 1'b0, 4'd3);

    // Async reset mid-grant with owner 5
    req = 16'h0020;
    tick();
    check_grant("pre_rst_grant", 1'b1, 4'd5);
    #2 rst = 1'b1;
    #1;
    check_grant("async_rst", 1'b0, 4'd0);
    check("async_rst_timeout", {31'd0, timeout}, 32'd0);
    tick();
    rst = 1'b0;
    req = 16'h0021;
    tick();
    check_grant("post_rst_ptr0", 1'b1, 4'd0);
    req = '0;
    tick();

    // Round-robin from ptr=0 with everyone requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      tick();
      check_grant($sformatf("rr_grant%0d", k), 1'b1, 4'(k));
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr_gap", {31'd0, grant_valid}, 32'd0);
    end
    // ptr=1
    req = 16'h4000;
    tick();
    check_grant("wrap_own14", 1'b1, 4'd14);
    req = 16'h8002;
    tick();
    check_grant("wrap_rel14", 1'b0, 4'd14);
    tick();
    check_grant("wrap_g15", 1'b1, 4'd15);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check_grant("wrap_g1", 1'b1, 4'd1);
    req = '0;
    tick();

    // Request drop by owner 7, then search from 8 wraps to 0
    req = 16'h0080;
    tick();
    check_grant("drop_own7", 1'b1, 4'd7);
    tick();
    check_grant("drop_hold7", 1'b1, 4'd7);
    req = 16'h0001;
    tick();
    check_grant("drop_rel7", 1'b0, 4'd7);
    req = 16'h0081;
    tick();
    check_grant("drop_wrap0", 1'b1, 4'd0);
    req = '0;
    tick();

    // Owner 2 holding with done=0
    req = 16'h0004;
    tick();
    check_grant("hold_own2", 1'b1, 4'd2);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      check_grant("to_hold", 1'b1, 4'd2);
      check("to_quiet", {31'd0, timeout}, 32'd0);
    end
    tick();
    check_grant("to_force", 1'b0, 4'd2);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    tick();
    check_grant("to_regrant", 1'b1, 4'd2);
    check("to_pulse_end", {31'd0, timeout}, 32'd0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      check("nto_hold", {27'd0, grant_valid, grant_idx, timeout}, {27'd0, 1'b1, 4'd2, 1'b0});
    end
`endif
    req = '0;
    tick();
    check_grant("final_idle", 1'b0, 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
